ext_mem_bootld: RTL and testbench

//  Synthesizable, parametrised external-memory endpoint for the ElectronNest top: boot streamer,

---
 rtl/ext_mem_bootld.sv | 220 ++++++++++++++++++++++
 tb/tb_ext_mem_bootld.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_bootld.sv
`default_nettype none
// ============================================================================
//  Module   : ext_mem_bootld
//  Purpose  : External-memory endpoint. Streams a boot image to the fabric,
//             answers loads with a fixed latency, and sinks stores arbitrated
//             against a host init port.
//  Revision : 1.0  initial release
// ============================================================================

package ext_mem_pkg;
  localparam int WIDTH_DATA   = 32;
  localparam int WIDTH_EXADDR = 16;
  localparam int WIDTH_INDEX  = 4;

  typedef struct packed {
    logic                   v;
    logic                   a;
    logic                   r;
    logic                   c;
    logic [WIDTH_INDEX-1:0] i;
    logic [WIDTH_DATA-1:0]  d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

module ext_mem_bootld
  import ext_mem_pkg::*;
#(
  parameter int                      DEPTH    = 1024,
  parameter int                      LD_LAT   = 1,
  parameter int                      BOOT_PRE = 3,
  parameter int                      BOOT_LEN = 5,
  parameter logic [WIDTH_EXADDR-1:0] IDX_CLR0 = 16'h0190,
  parameter logic [WIDTH_EXADDR-1:0] IDX_CLR1 = 16'h0290
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  input  logic                    I_Init_We,
  input  logic [WIDTH_EXADDR-1:0] I_Init_Addr,
  input  logic [WIDTH_DATA-1:0]   I_Init_Data,
  input  logic                    I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
  output FTk_t                    O_Ld_FTk,
  input  BTk_t                    I_Ld_BTk,
  input  logic                    I_St_Req,
  input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
  input  FTk_t                    I_St_FTk,
  output BTk_t                    O_St_BTk,
  output logic                    O_Booting
);

  // DEPTH is expected to be a power of two so that truncation equals modulo.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    BOOT = 2'd2,
    RUN  = 2'd3
  } state_t;

  // Skip empty boot phases so zero-length parameters still terminate in RUN.
  localparam state_t AFTER_IDLE = (BOOT_PRE > 0) ? PRE : ((BOOT_LEN > 0) ? BOOT : RUN);
  localparam state_t AFTER_PRE  = (BOOT_LEN > 0) ? BOOT : RUN;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   booting;
  FTk_t                   ld_tok;
  logic [WIDTH_INDEX-1:0] index;
  logic [WIDTH_DATA-1:0]  mem [DEPTH];

  logic accept;
  logic idx_hit;
  logic st_block;
  logic st_write;
  FTk_t new_tok;
  FTk_t pipe_tail;
  FTk_t boot_word;
  logic unused_bits;

  assign O_Ld_FTk  = ld_tok;
  assign O_Booting = booting;

  // Loads are only served once the boot image has been fully streamed.
  assign accept  = (state == RUN) && I_Ld_Req && !I_Ld_BTk.n;
  assign idx_hit = (I_Ld_Addr == IDX_CLR0) || (I_Ld_Addr == IDX_CLR1);

  // Stores back off while the host is preloading or the boot image is in flight.
  assign st_block = I_Init_We || (state == PRE) || (state == BOOT);
  assign st_write = I_St_Req && I_St_FTk.v && !st_block;

  assign unused_bits = ^{I_Ld_BTk.v, I_Ld_BTk.c, I_St_FTk.a, I_St_FTk.r,
                         I_St_FTk.c, I_St_FTk.i, I_Init_Addr, I_St_Addr};

  // Store back token: only the stall bit carries information.
  always_comb begin
    O_St_BTk   = '0;
    O_St_BTk.n = st_block;
  end

  // Boot word for the current counter position; PRE words carry zero data.
  always_comb begin
    boot_word   = '0;
    boot_word.v = 1'b1;
    if (state == PRE) begin
      boot_word.a = (cnt == '0);
    end else begin
      boot_word.a = (BOOT_PRE == 0) && (cnt == '0);
      boot_word.d = mem[cnt[AW-1:0]];
    end
  end

  // Load token captured at acceptance; the read sees pre-write contents.
  always_comb begin
    new_tok = '0;
    if (accept) begin
      new_tok.v = 1'b1;
      new_tok.i = index;
      new_tok.d = mem[I_Ld_Addr[AW-1:0]];
    end
  end

  generate
    if (LD_LAT <= 1) begin : g_lat1
      assign pipe_tail = new_tok;
    end else begin : g_pipe
      FTk_t stage [LD_LAT-1];
      // Delay line for accepted loads; the whole line freezes while stalled
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < LD_LAT - 1; k++) stage[k] <= '0;
        end else if (!I_Ld_BTk.n) begin
          stage[0] <= new_tok;
          for (int k = 1; k < LD_LAT - 1; k++) stage[k] <= stage[k-1];
        end
      end
      assign pipe_tail = stage[LD_LAT-2];
    end
  endgenerate

  // Boot sequencer and the registered load/boot output token
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      booting <= 1'b0;
      ld_tok  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_Boot) begin
            state   <= AFTER_IDLE;
            booting <= (AFTER_IDLE != RUN);
            cnt     <= '0;
          end
        end
        PRE: begin
          if (!I_Ld_BTk.n) begin
            ld_tok <= boot_word;
            if (cnt == CW'(BOOT_PRE - 1)) begin
              cnt     <= '0;
              state   <= AFTER_PRE;
              booting <= (AFTER_PRE != RUN);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        BOOT: begin
          if (!I_Ld_BTk.n) begin
            ld_tok <= boot_word;
            if (cnt == CW'(BOOT_LEN - 1)) begin
              cnt     <= '0;
              state   <= RUN;
              booting <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (!I_Ld_BTk.n) ld_tok <= pipe_tail;
        end
      endcase
    end
  end

  // Load index: address-triggered clear beats back-token clear beats increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index <= '0;
    end else if (accept && idx_hit) begin
      index <= '0;
    end else if (I_Ld_BTk.t) begin
      index <= '0;
    end else if (accept) begin
      index <= index + 1'b1;
    end
  end

  // Storage array: init port outranks stores; contents survive reset
  always_ff @(posedge clock) begin
    if (I_Init_We) begin
      mem[I_Init_Addr[AW-1:0]] <= I_Init_Data;
    end else if (st_write) begin
      mem[I_St_Addr[AW-1:0]] <= I_St_FTk.d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_bootld.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_mem_bootld
//  Purpose  : Self-checking bench for ext_mem_bootld against a transaction
//             level model (boot word list, in-flight load list, array memory).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ext_mem_bootld;
  import ext_mem_pkg::*;

  localparam int DEPTH    = 1024;
  localparam int LD_LAT   = 2;
  localparam int BOOT_PRE = 3;
  localparam int BOOT_LEN = 5;
  localparam int TOTAL    = BOOT_PRE + BOOT_LEN;
  localparam logic [15:0] CLR0 = 16'h0190;
  localparam logic [15:0] CLR1 = 16'h0290;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        boot;
  logic        init_we;
  logic [15:0] init_addr;
  logic [31:0] init_data;
  logic        ld_req;
  logic [15:0] ld_addr;
  FTk_t        ld_ftk;
  BTk_t        ld_btk;
  logic        st_req;
  logic [15:0] st_addr;
  FTk_t        st_ftk;
  BTk_t        st_btk;
  logic        booting;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0]            mdl_mem [DEPTH];
  bit                     started;
  int                     emitted;
  FTk_t                   exp_out;
  logic [WIDTH_INDEX-1:0] exp_idx;
  FTk_t                   q_tok [$];
  int                     q_rem [$];

  always #5 clock = ~clock;

  ext_mem_bootld #(
    .DEPTH   (DEPTH),
    .LD_LAT  (LD_LAT),
    .BOOT_PRE(BOOT_PRE),
    .BOOT_LEN(BOOT_LEN),
    .IDX_CLR0(CLR0),
    .IDX_CLR1(CLR1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .I_Boot     (boot),
    .I_Init_We  (init_we),
    .I_Init_Addr(init_addr),
    .I_Init_Data(init_data),
    .I_Ld_Req   (ld_req),
    .I_Ld_Addr  (ld_addr),
    .O_Ld_FTk   (ld_ftk),
    .I_Ld_BTk   (ld_btk),
    .I_St_Req   (st_req),
    .I_St_Addr  (st_addr),
    .I_St_FTk   (st_ftk),
    .O_St_BTk   (st_btk),
    .O_Booting  (booting)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic FTk_t boot_word(input int k);
    FTk_t w;
    w   = '0;
    w.v = 1'b1;
    w.a = (k == 0);
    if (k >= BOOT_PRE) w.d = mdl_mem[k - BOOT_PRE];
    return w;
  endfunction

  function automatic bit mdl_booting();
    return started && (emitted < TOTAL);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit   in_boot;
    bit   in_run;
    bit   acc;
    FTk_t t;
    in_boot = mdl_booting();
    in_run  = started && (emitted == TOTAL);
    acc     = in_run && ld_req && !ld_btk.n;
    if (acc) begin
      t   = '0;
      t.v = 1'b1;
      t.i = exp_idx;
      t.d = mdl_mem[int'(ld_addr) % DEPTH];
      q_tok.push_back(t);
      q_rem.push_back(LD_LAT);
    end
    if (!started) begin
      if (boot) started = 1'b1;
    end else if (!ld_btk.n) begin
      if (in_boot) begin
        exp_out = boot_word(emitted);
        emitted++;
      end else begin
        foreach (q_rem[k]) q_rem[k]--;
        if (q_rem.size() > 0 && q_rem[0] == 0) begin
          exp_out = q_tok.pop_front();
          void'(q_rem.pop_front());
        end else begin
          exp_out = '0;
        end
      end
    end
    if (acc && (ld_addr == CLR0 || ld_addr == CLR1)) exp_idx = '0;
    else if (ld_btk.t) exp_idx = '0;
    else if (acc) exp_idx = exp_idx + 1'b1;
    if (init_we) mdl_mem[int'(init_addr) % DEPTH] = init_data;
    else if (st_req && st_ftk.v && !in_boot) mdl_mem[int'(st_addr) % DEPTH] = st_ftk.d;
  endtask

  // One cycle: inputs already driven at a negedge.
  task automatic tick();
    #1;
    check("st_btk", 64'(st_btk), 64'({init_we || mdl_booting(), 3'b000}));
    model_edge();
    @(negedge clock);
    check("ld_ftk", 64'(ld_ftk), 64'(exp_out));
    check("booting", 64'(booting), 64'(mdl_booting()));
  endtask

  task automatic idle_inputs();
    boot = 0; init_we = 0; init_addr = '0; init_data = '0;
    ld_req = 0; ld_addr = '0; ld_btk = '0;
    st_req = 0; st_addr = '0; st_ftk = '0;
  endtask

  task automatic rand_store(input bit safe);
    st_req      = 1'($urandom);
    st_addr     = safe ? 16'($urandom_range(64, DEPTH - 1)) : 16'($urandom);
    st_ftk      = '0;
    st_ftk.v    = 1'($urandom);
    st_ftk.a    = 1'($urandom);
    st_ftk.i    = WIDTH_INDEX'($urandom);
    st_ftk.d    = $urandom;
  endtask

  function automatic logic [15:0] rand_ld_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return CLR0;
    if (r == 1) return CLR1;
    return 16'($urandom);
  endfunction

  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    check("rst_ftk", 64'(ld_ftk), 64'(0));
    check("rst_booting", 64'(booting), 64'(0));
    check("rst_st_btk", 64'(st_btk), 64'(0));
    started = 0; emitted = 0; exp_out = '0; exp_idx = '0;
    q_tok.delete(); q_rem.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    idle_inputs();
    started = 0; emitted = 0; exp_out = '0; exp_idx = '0;
    repeat (3) @(negedge clock);
    check("reset_ftk", 64'(ld_ftk), 64'(0));
    check("reset_booting", 64'(booting), 64'(0));
    check("reset_st_btk", 64'(st_btk), 64'(0));
    reset = 1'b0;

    // Preload the full array through aliased addresses; stores must be held off.
    for (int a = 0; a < DEPTH; a++) begin
      init_we   = 1'b1;
      init_addr = 16'(a + DEPTH * $urandom_range(0, 63));
      init_data = (a == 16'h0010) ? 32'h0000_DEAD : $urandom;
      rand_store(1'b1);
      tick();
    end
    init_we = 1'b0;

    // Stores in IDLE are accepted; loads are dropped.
    for (int c = 0; c < 40; c++) begin
      rand_store(1'b1);
      ld_req  = 1'($urandom);
      ld_addr = rand_ld_addr();
      tick();
    end

    // Start a boot, then reset partway through the BOOT words.
    boot = 1'b1; tick(); boot = 1'b0;
    guard = 0;
    while (emitted < BOOT_PRE + 2 && guard < 200) begin
      ld_btk.n = ($urandom_range(0, 3) == 0);
      rand_store(1'b1);
      tick();
      guard++;
    end
    idle_inputs();
    async_reset_pulse();

    // Full boot from scratch with random stalls.
    boot = 1'b1; tick(); boot = 1'b0;
    guard = 0;
    while (emitted < TOTAL && guard < 300) begin
      ld_btk.n = ($urandom_range(0, 2) == 0);
      boot     = 1'($urandom);
      ld_req   = 1'($urandom);
      ld_addr  = rand_ld_addr();
      rand_store(1'b1);
      tick();
      guard++;
    end
    check("boot_done", 64'(booting), 64'(0));
    idle_inputs();
    repeat (3) tick();

    // Load latency: 0x10 holds 0xDEAD, index starts at 0.
    ld_req = 1'b1; ld_addr = 16'h0010; tick();
    ld_req = 1'b0;
    check("lat_early_v", 64'(ld_ftk.v), 64'(0));
    tick();
    check("lat_v", 64'(ld_ftk.v), 64'(1));
    check("lat_d", 64'(ld_ftk.d), 64'(32'h0000_DEAD));
    check("lat_i", 64'(ld_ftk.i), 64'(0));
    for (int k = 0; k < 3; k++) begin
      ld_req = 1'b1; ld_addr = 16'(16'h0011 + k); tick();
    end
    ld_req = 1'b0;
    repeat (3) tick();

    // Two loads in flight, then a two-cycle stall.
    ld_req = 1'b1; ld_addr = 16'h0005; tick();
    ld_addr = 16'h0006; tick();
    ld_req = 1'b0; ld_btk.n = 1'b1; tick(); tick();
    ld_btk.n = 1'b0;
    repeat (4) tick();

    // Walk the index to 7, hit the clear address, then clear via back token.
    guard = 0;
    while (exp_idx != 7 && guard < 40) begin
      ld_req = 1'b1; ld_addr = 16'(16'h0020 + guard); tick();
      guard++;
    end
    ld_addr = CLR0; tick();
    ld_addr = 16'h0021; tick();
    ld_addr = 16'h0022; ld_btk.t = 1'b1; tick();
    ld_btk.t = 1'b0; ld_addr = 16'h0023; tick();
    ld_req = 1'b0;
    repeat (3) tick();

    // Store collides with init; same-cycle load must see the old value.
    init_we = 1'b1; init_addr = 16'h0030; init_data = $urandom;
    st_req = 1'b1; st_addr = 16'h0020; st_ftk = '0; st_ftk.v = 1'b1; st_ftk.d = 32'h55;
    ld_req = 1'b1; ld_addr = 16'h0020; tick();
    init_we = 1'b0; ld_req = 1'b0; tick();
    st_req = 1'b0;
    ld_req = 1'b1; ld_addr = 16'h0020; tick();
    ld_req = 1'b0; tick();
    check("store_landed", 64'(ld_ftk.d), 64'(32'h55));
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      boot      = 1'($urandom);
      init_we   = ($urandom_range(0, 9) == 0);
      init_addr = 16'($urandom);
      init_data = $urandom;
      ld_req    = ($urandom_range(0, 9) < 6);
      ld_addr   = rand_ld_addr();
      ld_btk    = '0;
      ld_btk.n  = ($urandom_range(0, 3) == 0);
      ld_btk.t  = ($urandom_range(0, 19) == 0);
      ld_btk.v  = 1'($urandom);
      ld_btk.c  = 1'($urandom);
      rand_store(1'b0);
      tick();
    end

    idle_inputs();
    repeat (LD_LAT + 4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
